// File: rtl/cache_mem_arb_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
package cache_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // REQ_D encodes as 0 so every register, including last_grant, resets to zero.
    typedef enum logic {
        REQ_I = 1'b1,
        REQ_D = 1'b0
    } requester_e;

    localparam logic MEM_OP_READ  = 1'b1;
    localparam logic MEM_OP_WRITE = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin picker; purely combinational, the history register lives in the parent.
module rr_arbiter_2 (
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);
    import cache_mem_arb_pkg::*;

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = REQ_D;
        if (i_req && d_req) begin
            grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
        end else if (i_req) begin
            grant = REQ_I;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/write-backs,
// one transaction at a time, with a registered one-cycle completion pulse.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req_valid,
    input  logic              d_req_op,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              timeout_err
);
    import cache_mem_arb_pkg::*;

    localparam int unsigned      CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    requester_e        grant_q, grant_d;
    requester_e        last_grant_q, last_grant_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              arb_valid;
    logic              arb_grant;
    logic [CNT_W-1:0]  cnt_inc;

    rr_arbiter_2 u_arb (
        .i_req       (i_req_valid),
        .d_req       (d_req_valid),
        .last_grant  (last_grant_q),
        .grant_valid (arb_valid),
        .grant       (arb_grant)
    );

    // Saturating so a disabled timeout never wraps the counter.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = requester_e'(arb_grant);
                    if (requester_e'(arb_grant) == REQ_I) begin
                        op_d    = MEM_OP_READ;
                        addr_d  = i_req_addr;
                        wdata_d = '0;
                    end else begin
                        op_d    = d_req_op;
                        addr_d  = d_req_addr;
                        wdata_d = d_req_wdata;
                    end
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    rdata_d = (op_q == MEM_OP_READ) ? mem_data : '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (TIMEOUT != 0 && cnt_inc == CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        rdata_d   = '0;
                        state_d   = RESP;
                    end
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            grant_q      <= REQ_D;
            last_grant_q <= REQ_D;
            op_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        mem_valid   = (state_q == BUSY);
        mem_op      = mem_valid & op_q;
        mem_addr    = mem_valid ? addr_q : '0;
        mem_wdata   = mem_valid ? wdata_q : '0;
        i_ready     = (state_q == RESP) && (grant_q == REQ_I);
        d_ready     = (state_q == RESP) && (grant_q == REQ_D);
        i_rdata     = i_ready ? rdata_q : '0;
        d_rdata     = d_ready ? rdata_q : '0;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomised and directed bench for cache_mem_arbiter against a transaction-timeline model.
module tb_cache_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int          TMO = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          i_req_valid;
    logic [AW-1:0] i_req_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req_valid;
    logic          d_req_op;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_valid;
    logic          mem_op;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_data;
    logic          timeout_err;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .i_ready     (i_ready),
        .i_rdata     (i_rdata),
        .d_req_valid (d_req_valid),
        .d_req_op    (d_req_op),
        .d_req_addr  (d_req_addr),
        .d_req_wdata (d_req_wdata),
        .d_ready     (d_ready),
        .d_rdata     (d_rdata),
        .mem_valid   (mem_valid),
        .mem_op      (mem_op),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int failures = 0;

    // Model: each grant at edge g fixes the whole timeline (busy edges, pulse edge, next free edge).
    int          e = 0;
    int          free_e = 0;
    bit          active = 0;
    int          g = 0, lat = 0, blen = 0;
    bit          tmo = 0, who_d = 0, t_op = 0;
    logic [31:0] t_addr = 0, t_wdata = 0, t_mdata = 0, t_rd = 0;
    bit          last_d = 1;
    bit          exp_to = 0;

    bit          i_pend = 0, i_gnt = 0, d_pend = 0, d_gnt = 0;
    bit          dop = 0;
    logic [31:0] ia = 0, da = 0, dw = 0;

    int          gen_pct = 0, stray_pct = 0, force_lat = 0;
    bit          drop_en = 0, force_data_en = 0;
    logic [31:0] force_data = 0;

    int          obs_order[$];
    logic [31:0] obs_rdata = 0, obs_addr = 0, obs_wdata = 0;
    logic        obs_op = 0;
    int          obs_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_reset();
        active = 0;
        free_e = 0;
        last_d = 1;
        exp_to = 0;
        i_pend = 0;
        i_gnt  = 0;
        d_pend = 0;
        d_gnt  = 0;
    endtask

    task automatic post_i(input logic [31:0] a);
        i_pend = 1;
        ia = a;
        i_req_valid = 1;
        i_req_addr = a;
    endtask

    task automatic post_d(input bit op, input logic [31:0] a, input logic [31:0] w);
        d_pend = 1;
        dop = op;
        da = a;
        dw = w;
        d_req_valid = 1;
        d_req_op = op;
        d_req_addr = a;
        d_req_wdata = w;
    endtask

    task automatic drive();
        int nb;
        nb = e + 1;
        mem_ready = 0;
        mem_data = $urandom();
        if (active && nb == g + lat && lat <= blen) begin
            mem_ready = 1;
            mem_data = t_mdata;
        end else if (stray_pct > 0 && !(active && nb > g && nb <= g + blen)
                     && $urandom_range(0, 99) < stray_pct) begin
            mem_ready = 1;
        end
        if (!i_pend && gen_pct > 0 && $urandom_range(0, 99) < gen_pct) begin
            i_pend = 1;
            ia = $urandom();
        end
        if (!d_pend && gen_pct > 0 && $urandom_range(0, 99) < gen_pct) begin
            d_pend = 1;
            dop = 1'($urandom_range(0, 1));
            da = $urandom();
            dw = $urandom();
        end
        i_req_valid = i_pend && !(i_gnt && drop_en && $urandom_range(0, 3) == 0);
        i_req_addr  = i_pend ? ia : $urandom();
        d_req_valid = d_pend && !(d_gnt && drop_en && $urandom_range(0, 3) == 0);
        d_req_op    = d_pend ? dop : 1'($urandom_range(0, 1));
        d_req_addr  = d_pend ? da : $urandom();
        d_req_wdata = d_pend ? dw : $urandom();
    endtask

    // One clock: model grant decision, compare all outputs, record observations, drive next inputs.
    task automatic step();
        bit in_busy, pulse;
        @(posedge clk);
        e++;
        @(negedge clk);
        if (e >= free_e && (i_req_valid || d_req_valid)) begin
            who_d  = (i_req_valid && d_req_valid) ? !last_d : d_req_valid;
            active = 1;
            g = e;
            if (who_d) begin
                t_op = d_req_op; t_addr = d_req_addr; t_wdata = d_req_wdata; d_gnt = 1;
            end else begin
                t_op = 1; t_addr = i_req_addr; t_wdata = 0; i_gnt = 1;
            end
            lat     = (force_lat > 0) ? force_lat : $urandom_range(1, 6);
            tmo     = lat > TMO;
            blen    = tmo ? TMO : lat;
            t_mdata = force_data_en ? force_data : $urandom();
            t_rd    = (t_op && !tmo) ? t_mdata : 32'h0;
            free_e  = e + blen + 2;
            last_d  = who_d;
            obs_busy = 0;
        end
        in_busy = active && e >= g && e < g + blen;
        pulse   = active && e == g + blen;
        if (pulse && tmo) exp_to = 1;
        chk("mem_valid", mem_valid, in_busy);
        chk("i_ready", i_ready, pulse && !who_d);
        chk("d_ready", d_ready, pulse && who_d);
        chk("i_rdata", i_rdata, (pulse && !who_d) ? t_rd : 32'h0);
        chk("d_rdata", d_rdata, (pulse && who_d) ? t_rd : 32'h0);
        chk("timeout_err", timeout_err, exp_to);
        if (in_busy) begin
            chk("mem_op", mem_op, t_op);
            chk("mem_addr", mem_addr, t_addr);
            if (who_d) chk("mem_wdata", mem_wdata, t_wdata);
        end
        if (mem_valid) begin
            obs_busy++;
            obs_op = mem_op;
            obs_addr = mem_addr;
            obs_wdata = mem_wdata;
        end
        if (i_ready) begin obs_order.push_back(0); obs_rdata = i_rdata; end
        if (d_ready) begin obs_order.push_back(1); obs_rdata = d_rdata; end
        if (pulse) begin
            if (who_d) begin d_pend = 0; d_gnt = 0; end
            else begin i_pend = 0; i_gnt = 0; end
        end
        drive();
    endtask

    task automatic run_pulses(input int n, input int budget);
        int target, k;
        target = obs_order.size() + n;
        k = 0;
        while (obs_order.size() < target && k < budget) begin
            step();
            k++;
        end
        chk("pulse_wait", obs_order.size() >= target, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((i_pend || d_pend || (active && e < free_e)) && k < 200) begin
            step();
            k++;
        end
    endtask

    task automatic clear_inputs();
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_op = 0; d_req_addr = 0; d_req_wdata = 0;
        mem_ready = 0; mem_data = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        nrst = 1;
        model_reset();
    endtask

    initial begin
        int n;
        nrst = 0;
        clear_inputs();
        i_req_valid = 1;
        i_req_addr = 32'h44;
        mem_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        clear_inputs();
        nrst = 1;
        model_reset();

        // I-cache read, memory answers on the second busy cycle
        force_lat = 2; force_data_en = 1; force_data = 32'hCAFE0001;
        post_i(32'h100);
        run_pulses(1, 20);
        chk("t1_who", obs_order[obs_order.size()-1], 0);
        chk("t1_rdata", obs_rdata, 32'hCAFE0001);
        chk("t1_addr", obs_addr, 32'h100);
        chk("t1_op", obs_op, 1);
        chk("t1_busy", obs_busy, 2);

        // D-cache write-back
        force_lat = 1;
        post_d(0, 32'h2C0, 32'h12345678);
        run_pulses(1, 20);
        chk("t2_who", obs_order[obs_order.size()-1], 1);
        chk("t2_rdata", obs_rdata, 0);
        chk("t2_op", obs_op, 0);
        chk("t2_wdata", obs_wdata, 32'h12345678);
        chk("t2_busy", obs_busy, 1);

        // Tie right after reset, then both held so grants alternate
        drain();
        do_reset();
        force_data_en = 0;
        post_i(32'h40);
        post_d(1, 32'h80, 0);
        run_pulses(2, 30);
        n = obs_order.size();
        chk("t3_first", obs_order[n-2], 0);
        chk("t3_second", obs_order[n-1], 1);
        gen_pct = 100;
        run_pulses(4, 60);
        n = obs_order.size();
        chk("t3_alt0", obs_order[n-4], 0);
        chk("t3_alt1", obs_order[n-3], 1);
        chk("t3_alt2", obs_order[n-2], 0);
        chk("t3_alt3", obs_order[n-1], 1);
        gen_pct = 0;
        drain();

        // Memory never answers: four busy cycles then timeout, next request normal
        force_lat = 10; force_data_en = 1; force_data = 32'h0000DEAD;
        post_i(32'h300);
        run_pulses(1, 20);
        chk("t4_busy", obs_busy, TMO);
        chk("t4_rdata", obs_rdata, 0);
        chk("t4_err", timeout_err, 1);
        force_lat = 2; force_data = 32'hBEEF0002;
        post_d(1, 32'h304, 0);
        run_pulses(1, 20);
        chk("t4_next_who", obs_order[obs_order.size()-1], 1);
        chk("t4_next_rdata", obs_rdata, 32'hBEEF0002);
        chk("t4_err_sticky", timeout_err, 1);
        drain();

        // Stray mem_ready while idle
        n = obs_order.size();
        stray_pct = 100;
        repeat (4) step();
        stray_pct = 0;
        chk("t6_pulses", obs_order.size(), n);
        chk("t6_mem_valid", mem_valid, 0);

        // Reset in the middle of a busy transaction
        force_lat = 5;
        post_i(32'h500);
        repeat (2) step();
        chk("t5_busy", mem_valid, 1);
        #2 nrst = 0;
        #1;
        chk("t5_mem_valid", mem_valid, 0);
        chk("t5_i_ready", i_ready, 0);
        chk("t5_err", timeout_err, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_pulse", i_ready | d_ready, 0);
        end
        clear_inputs();
        nrst = 1;
        model_reset();
        force_lat = 1;
        post_i(32'h600);
        post_d(0, 32'h700, 32'h55);
        run_pulses(2, 30);
        n = obs_order.size();
        chk("t5_tie_first", obs_order[n-2], 0);
        chk("t5_tie_second", obs_order[n-1], 1);
        drain();

        // Random traffic
        force_lat = 0; force_data_en = 0;
        gen_pct = 40; stray_pct = 10; drop_en = 1;
        repeat (3000) step();
        gen_pct = 0; stray_pct = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
